stagen_hazard_unit: RTL and testbench

Parametrised hazard/stall controller for an N-stage in-order RV32 pipeline. It is the successor of the fixed 3-stage hazard control. The block keeps an internal shadow pipeline of in-flight destination registers to detect RAW and load-use hazards. It generates per-stage stall and flush vectors, and sequences trap/return redirects through a drain state machine. It sits beside the pipeline and talks to fetch, issue, execute, memory and the priv block.

---
 rtl/stagen_hazard_unit.sv | 194 +++++++++++++++++++
 tb/tb_stagen_hazard_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stagen_hazard_unit.sv
// Hazard and stall controller for an N-stage in-order RV32 pipeline.
// A shadow pipeline tracks in-flight destination registers. It is used to
// detect RAW and load-use hazards, drive per-stage stall/flush vectors and
// sequence trap/xRET redirects through a drain state machine.
module stagen_hazard_unit #(
    parameter int NUM_STAGES = 5,
    parameter int MEM_STAGE  = 3,
    parameter int FWD_EN     = 1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_rs1,
    input  logic [4:0]            issue_rs2,
    input  logic [4:0]            issue_rd,
    input  logic                  issue_reg_write,
    input  logic                  issue_is_load,
    input  logic                  i_mem_busy,
    input  logic                  d_mem_busy,
    input  logic                  mispredict,
    input  logic                  exception,
    input  logic                  ret,
    input  logic [31:0]           priv_pc_in,
    output logic                  pc_en,
    output logic                  npc_sel,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  iren,
    output logic                  insert_priv_pc,
    output logic [31:0]           priv_pc,
    output logic [31:0]           hazard_cycles
);

    // Bits 0..MEM_STAGE set: the front of the pipe up to and including memory.
    localparam logic [NUM_STAGES-1:0] LOW_MASK =
        {NUM_STAGES{1'b1}} >> (NUM_STAGES - MEM_STAGE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0] priv_pc_q, priv_pc_d;
    logic [31:0] hazard_cycles_q, hazard_cycles_d;

    // Shadow pipeline: one entry per stage 2..NUM_STAGES-1.
    logic [NUM_STAGES-1:2] sh_valid_q, sh_valid_d;
    logic [NUM_STAGES-1:2] sh_wen_q, sh_wen_d;
    logic [NUM_STAGES-1:2] sh_load_q, sh_load_d;
    logic [4:0]            sh_rd_q [NUM_STAGES-1:2];
    logic [4:0]            sh_rd_d [NUM_STAGES-1:2];

    logic [NUM_STAGES-1:2] src_hit;
    logic                  data_hazard;
    logic                  hazard_taken;

    // Per-stage source match. With bypassing only a load that has not yet
    // reached memory can still block. Without bypassing any pending write blocks.
    genvar gi;
    generate
        for (gi = 2; gi < NUM_STAGES; gi++) begin : g_match
            logic rd_live;
            logic kind_ok;
            assign rd_live = sh_valid_q[gi] && sh_wen_q[gi] && (sh_rd_q[gi] != 5'd0);
            assign kind_ok = (FWD_EN == 0) || (sh_load_q[gi] && (gi < MEM_STAGE));
            assign src_hit[gi] = rd_live && kind_ok &&
                                 ((sh_rd_q[gi] == issue_rs1) || (sh_rd_q[gi] == issue_rs2));
        end
    endgenerate

    assign data_hazard   = issue_valid && (|src_hit);
    assign priv_pc       = priv_pc_q;
    assign hazard_cycles = hazard_cycles_q;

    // Pipeline control outputs, resolved by a fixed priority chain.
    always_comb begin
        pc_en          = 1'b1;
        npc_sel        = 1'b0;
        stall          = '0;
        flush          = '0;
        iren           = 1'b1;
        insert_priv_pc = 1'b0;
        hazard_taken   = 1'b0;
        if (state_q == ST_DRAIN) begin
            stall = LOW_MASK;
            iren  = 1'b0;
            pc_en = 1'b0;
        end else if (state_q == ST_TRAP) begin
            flush          = LOW_MASK;
            insert_priv_pc = 1'b1;
            pc_en          = 1'b1;
        end else if (d_mem_busy) begin
            stall = LOW_MASK;
            pc_en = 1'b0;
        end else if (mispredict) begin
            // Stage 2 is never stalled here, so the branch itself advances.
            flush[1:0] = 2'b11;
            npc_sel    = 1'b1;
            pc_en      = 1'b1;
        end else if (data_hazard) begin
            stall[1:0]   = 2'b11;
            pc_en        = 1'b0;
            hazard_taken = 1'b1;
        end else if (i_mem_busy) begin
            stall[0] = 1'b1;
            flush[1] = 1'b1;
            pc_en    = 1'b0;
        end
    end

    // Shadow pipeline advance: hold when stalled, bubble behind a stall, clear on flush.
    always_comb begin
        sh_valid_d = sh_valid_q;
        sh_wen_d   = sh_wen_q;
        sh_load_d  = sh_load_q;
        sh_rd_d    = sh_rd_q;
        if (flush[2] || (!stall[2] && (stall[1] || flush[1] || !issue_valid))) begin
            sh_valid_d[2] = 1'b0;
            sh_wen_d[2]   = 1'b0;
            sh_load_d[2]  = 1'b0;
            sh_rd_d[2]    = 5'd0;
        end else if (!stall[2]) begin
            sh_valid_d[2] = 1'b1;
            sh_wen_d[2]   = issue_reg_write;
            sh_load_d[2]  = issue_is_load;
            sh_rd_d[2]    = issue_rd;
        end
        for (int k = 3; k < NUM_STAGES; k++) begin
            if (flush[k] || (!stall[k] && stall[k-1])) begin
                sh_valid_d[k] = 1'b0;
                sh_wen_d[k]   = 1'b0;
                sh_load_d[k]  = 1'b0;
                sh_rd_d[k]    = 5'd0;
            end else if (!stall[k]) begin
                sh_valid_d[k] = sh_valid_q[k-1];
                sh_wen_d[k]   = sh_wen_q[k-1];
                sh_load_d[k]  = sh_load_q[k-1];
                sh_rd_d[k]    = sh_rd_q[k-1];
            end
        end
    end

    // Redirect sequencing and the stall-cycle counter.
    always_comb begin
        state_d         = state_q;
        priv_pc_d       = priv_pc_q;
        hazard_cycles_d = hazard_cycles_q + 32'(hazard_taken);
        case (state_q)
            ST_IDLE: begin
                if (exception) begin
                    state_d   = ST_DRAIN;
                    priv_pc_d = priv_pc_in;
                end else if (ret) begin
                    state_d   = ST_DRAIN;
                    priv_pc_d = priv_pc_in;
                end
            end
            ST_DRAIN: begin
                if (!d_mem_busy && !i_mem_busy) begin
                    state_d = ST_TRAP;
                end
            end
            ST_TRAP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q         <= ST_IDLE;
            priv_pc_q       <= '0;
            hazard_cycles_q <= '0;
            sh_valid_q      <= '0;
            sh_wen_q        <= '0;
            sh_load_q       <= '0;
            for (int k = 2; k < NUM_STAGES; k++) begin
                sh_rd_q[k] <= '0;
            end
        end else begin
            state_q         <= state_d;
            priv_pc_q       <= priv_pc_d;
            hazard_cycles_q <= hazard_cycles_d;
            sh_valid_q      <= sh_valid_d;
            sh_wen_q        <= sh_wen_d;
            sh_load_q       <= sh_load_d;
            sh_rd_q         <= sh_rd_d;
        end
    end

endmodule

// File: tb/tb_stagen_hazard_unit.sv
// Bench for stagen_hazard_unit. Two instances (with and without bypass) share
// the stimulus and are checked every cycle against a stage-level model.
// Directed scenarios come first, then randomized traffic.
module tb_stagen_hazard_unit;
    localparam int NS  = 5;
    localparam int MEM = 3;

    logic        CLK, nRST;
    logic        issue_valid, issue_reg_write, issue_is_load;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        i_mem_busy, d_mem_busy, mispredict, exception, ret;
    logic [31:0] priv_pc_in;

    logic          pc_en_a, npc_sel_a, iren_a, ins_a;
    logic [NS-1:0] stall_a, flush_a;
    logic [31:0]   priv_pc_a, hc_a;
    logic          pc_en_b, npc_sel_b, iren_b, ins_b;
    logic [NS-1:0] stall_b, flush_b;
    logic [31:0]   priv_pc_b, hc_b;

    stagen_hazard_unit #(.NUM_STAGES(NS), .MEM_STAGE(MEM), .FWD_EN(1)) dut_fwd (
        .CLK(CLK), .nRST(nRST), .issue_valid(issue_valid), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_rd(issue_rd), .issue_reg_write(issue_reg_write),
        .issue_is_load(issue_is_load), .i_mem_busy(i_mem_busy), .d_mem_busy(d_mem_busy),
        .mispredict(mispredict), .exception(exception), .ret(ret), .priv_pc_in(priv_pc_in),
        .pc_en(pc_en_a), .npc_sel(npc_sel_a), .stall(stall_a), .flush(flush_a),
        .iren(iren_a), .insert_priv_pc(ins_a), .priv_pc(priv_pc_a), .hazard_cycles(hc_a)
    );

    stagen_hazard_unit #(.NUM_STAGES(NS), .MEM_STAGE(MEM), .FWD_EN(0)) dut_nofwd (
        .CLK(CLK), .nRST(nRST), .issue_valid(issue_valid), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_rd(issue_rd), .issue_reg_write(issue_reg_write),
        .issue_is_load(issue_is_load), .i_mem_busy(i_mem_busy), .d_mem_busy(d_mem_busy),
        .mispredict(mispredict), .exception(exception), .ret(ret), .priv_pc_in(priv_pc_in),
        .pc_en(pc_en_b), .npc_sel(npc_sel_b), .stall(stall_b), .flush(flush_b),
        .iren(iren_b), .insert_priv_pc(ins_b), .priv_pc(priv_pc_b), .hazard_cycles(hc_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        bit       v;
        bit [4:0] rd;
        bit       w;
        bit       ld;
    } ent_t;

    ent_t      m_ent [2][NS];   // [config][stage], stages 2..NS-1 used
    int        m_mode;          // 0 normal, 1 draining, 2 trap cycle
    bit [31:0] m_ppc;
    bit [31:0] m_hc [2];

    bit [NS-1:0] e_stall [2];
    bit [NS-1:0] e_flush [2];
    bit          e_pc_en [2], e_npc [2], e_iren [2], e_ins [2], e_hz [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < NS; k++) m_ent[c][k] = '0;
            m_hc[c] = 0;
        end
        m_mode = 0;
        m_ppc  = 0;
    endfunction

    // Does the instruction in stage 1 read a register still owed by an older one?
    function automatic bit model_hazard(int c);
        if (!issue_valid) return 1'b0;
        for (int k = 2; k < NS; k++) begin
            if (m_ent[c][k].v && m_ent[c][k].w && m_ent[c][k].rd != 0 &&
                (m_ent[c][k].rd == issue_rs1 || m_ent[c][k].rd == issue_rs2)) begin
                if (c == 1) return 1'b1;
                if (m_ent[c][k].ld && k < MEM) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic void model_eval();
        for (int c = 0; c < 2; c++) begin
            bit [NS-1:0] front;
            front = '0;
            for (int s = 0; s <= MEM; s++) front[s] = 1'b1;
            e_stall[c] = '0; e_flush[c] = '0; e_pc_en[c] = 1; e_npc[c] = 0;
            e_iren[c] = 1; e_ins[c] = 0; e_hz[c] = 0;
            if (m_mode == 1) begin
                e_stall[c] = front; e_iren[c] = 0; e_pc_en[c] = 0;
            end else if (m_mode == 2) begin
                e_flush[c] = front; e_ins[c] = 1;
            end else if (d_mem_busy) begin
                e_stall[c] = front; e_pc_en[c] = 0;
            end else if (mispredict) begin
                e_flush[c] = 5'b00011; e_npc[c] = 1;
            end else if (model_hazard(c)) begin
                e_stall[c] = 5'b00011; e_pc_en[c] = 0; e_hz[c] = 1;
            end else if (i_mem_busy) begin
                e_stall[c] = 5'b00001; e_flush[c] = 5'b00010; e_pc_en[c] = 0;
            end
        end
    endfunction

    function automatic void model_update();
        for (int c = 0; c < 2; c++) begin
            ent_t nx [NS];
            for (int k = 0; k < NS; k++) nx[k] = m_ent[c][k];
            for (int k = NS - 1; k >= 3; k--) begin
                if (e_flush[c][k]) nx[k] = '0;
                else if (!e_stall[c][k]) nx[k] = e_stall[c][k-1] ? '0 : m_ent[c][k-1];
            end
            if (e_flush[c][2]) nx[2] = '0;
            else if (!e_stall[c][2]) begin
                if (issue_valid && !e_stall[c][1] && !e_flush[c][1])
                    nx[2] = '{v: 1'b1, rd: issue_rd, w: issue_reg_write, ld: issue_is_load};
                else
                    nx[2] = '0;
            end
            for (int k = 0; k < NS; k++) m_ent[c][k] = nx[k];
            m_hc[c] = m_hc[c] + 32'(e_hz[c]);
        end
        case (m_mode)
            0: if (exception || ret) begin m_mode = 1; m_ppc = priv_pc_in; end
            1: if (!d_mem_busy && !i_mem_busy) m_mode = 2;
            default: m_mode = 0;
        endcase
    endfunction

    // ---------------- compare process ----------------
    task automatic eval_check();
        #1;
        model_eval();
        cyc++;
        $display("cyc %0d v=%0b rs=%0d,%0d rd=%0d w=%0b ld=%0b db=%0b ib=%0b mp=%0b ex=%0b rt=%0b | stall=%b/%b flush=%b/%b hc=%0d/%0d",
                 cyc, issue_valid, issue_rs1, issue_rs2, issue_rd, issue_reg_write, issue_is_load,
                 d_mem_busy, i_mem_busy, mispredict, exception, ret,
                 stall_a, stall_b, flush_a, flush_b, hc_a, hc_b);
        chk("fwd.stall", 32'(stall_a), 32'(e_stall[0]));
        chk("fwd.flush", 32'(flush_a), 32'(e_flush[0]));
        chk("fwd.ctl", {28'd0, pc_en_a, npc_sel_a, iren_a, ins_a},
            {28'd0, e_pc_en[0], e_npc[0], e_iren[0], e_ins[0]});
        chk("fwd.priv_pc", priv_pc_a, m_ppc);
        chk("fwd.hazard_cycles", hc_a, m_hc[0]);
        chk("nofwd.stall", 32'(stall_b), 32'(e_stall[1]));
        chk("nofwd.flush", 32'(flush_b), 32'(e_flush[1]));
        chk("nofwd.ctl", {28'd0, pc_en_b, npc_sel_b, iren_b, ins_b},
            {28'd0, e_pc_en[1], e_npc[1], e_iren[1], e_ins[1]});
        chk("nofwd.priv_pc", priv_pc_b, m_ppc);
        chk("nofwd.hazard_cycles", hc_b, m_hc[1]);
    endtask

    task automatic advance();
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    task automatic set_idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        issue_reg_write = 0; issue_is_load = 0;
        i_mem_busy = 0; d_mem_busy = 0; mispredict = 0; exception = 0; ret = 0;
        priv_pc_in = 32'h0;
    endtask

    task automatic set_issue(input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic w, input logic ld);
        issue_valid = 1; issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
        issue_reg_write = w; issue_is_load = ld;
    endtask

    task automatic do_reset();
        set_idle();
        nRST = 1'b0;
        model_reset();
        eval_check();
        chk("rst.stall", 32'(stall_a), 32'h0);
        chk("rst.pc_en_iren", {30'd0, pc_en_a, iren_a}, 32'h3);
        chk("rst.hazard_cycles", hc_b, 32'h0);
        chk("rst.priv_pc", priv_pc_a, 32'h0);
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic drain();
        repeat (4) begin
            set_idle();
            eval_check();
            advance();
        end
    endtask

    initial begin
        int cnt;
        bit done;
        nRST = 1'b1;
        set_idle();
        model_reset();
        #2;
        do_reset();

        // Load-use with bypass: one stall cycle, counter reaches 1.
        set_issue(5'd0, 5'd0, 5'd5, 1, 1);
        eval_check(); advance();
        set_issue(5'd5, 5'd0, 5'd6, 1, 0);
        eval_check();
        chk("t1.stall_first", 32'(stall_a), 32'h03);
        advance();
        eval_check();
        chk("t1.stall_second", 32'(stall_a), 32'h00);
        chk("t1.hazard_cycles", hc_a, 32'd1);
        advance();
        drain();

        // No bypass: dependent ALU op waits until the writer leaves stage 4.
        set_issue(5'd0, 5'd0, 5'd7, 1, 0);
        eval_check(); advance();
        cnt = 0; done = 0;
        for (int i = 0; i < 6 && !done; i++) begin
            set_issue(5'd1, 5'd7, 5'd8, 1, 0);
            eval_check();
            if (stall_b[1]) cnt++; else done = 1;
            advance();
        end
        chk("t2.stall_len", 32'(cnt), 32'd3);
        drain();
        set_issue(5'd0, 5'd0, 5'd0, 1, 0);
        eval_check(); advance();
        set_issue(5'd0, 5'd0, 5'd1, 1, 0);
        eval_check();
        chk("t2.x0_no_stall", 32'(stall_b), 32'h0);
        advance();
        drain();

        // Memory busy for three cycles with a writer sitting in stage 3.
        set_issue(5'd0, 5'd0, 5'd9, 1, 0);
        eval_check(); advance();
        set_idle();
        eval_check(); advance();
        for (int i = 0; i < 3; i++) begin
            set_idle();
            d_mem_busy = 1;
            set_issue(5'd9, 5'd0, 5'd10, 1, 0);
            eval_check();
            chk("t3.busy_stall_fwd", 32'(stall_a), 32'h0f);
            chk("t3.busy_stall_nofwd", 32'(stall_b), 32'h0f);
            advance();
        end
        d_mem_busy = 0;
        eval_check();
        chk("t3.writer_kept_nofwd", 32'(stall_b), 32'h03);
        chk("t3.writer_kept_fwd", 32'(stall_a), 32'h00);
        advance();
        drain();

        // Mispredict, then the same request masked by memory busy.
        set_idle(); mispredict = 1;
        eval_check();
        chk("t4.flush", 32'(flush_a), 32'h03);
        chk("t4.npc_pc_en", {30'd0, npc_sel_a, pc_en_a}, 32'h3);
        advance();
        repeat (2) begin
            d_mem_busy = 1; mispredict = 1;
            eval_check();
            chk("t4.masked_npc", 32'(npc_sel_a), 32'h0);
            chk("t4.masked_flush", 32'(flush_a), 32'h0);
            advance();
        end
        d_mem_busy = 0;
        eval_check();
        chk("t4.released_npc", 32'(npc_sel_b), 32'h1);
        advance();
        drain();

        // Exception while memory busy: two drain cycles then one trap cycle.
        set_idle(); d_mem_busy = 1; exception = 1; priv_pc_in = 32'h200;
        eval_check(); advance();
        set_idle(); d_mem_busy = 1; priv_pc_in = 32'hdead;
        eval_check();
        chk("t5.drain1_stall", 32'(stall_a), 32'h0f);
        chk("t5.drain1_iren", 32'(iren_a), 32'h0);
        advance();
        set_idle();
        eval_check();
        chk("t5.drain2_iren", 32'(iren_b), 32'h0);
        advance();
        eval_check();
        chk("t5.trap_flush", 32'(flush_a), 32'h0f);
        chk("t5.trap_insert", 32'(ins_a), 32'h1);
        chk("t5.trap_priv_pc", priv_pc_a, 32'h200);
        chk("t5.trap_pc_en", 32'(pc_en_b), 32'h1);
        advance();
        eval_check();
        chk("t5.after_trap", {30'd0, ins_a, iren_a}, 32'h1);
        advance();

        // Reset asserted in the middle of a drain.
        set_idle(); d_mem_busy = 1; ret = 1; priv_pc_in = 32'h300;
        eval_check(); advance();
        set_idle(); d_mem_busy = 1;
        eval_check();
        chk("t6.in_drain", 32'(iren_a), 32'h0);
        do_reset();
        set_idle();
        eval_check();
        chk("t6.after_release", {27'd0, stall_a}, 32'h0);
        advance();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                issue_valid     = ($urandom_range(0, 9) < 7);
                issue_rs1       = 5'($urandom_range(0, 7));
                issue_rs2       = 5'($urandom_range(0, 7));
                issue_rd        = 5'($urandom_range(0, 7));
                issue_reg_write = ($urandom_range(0, 9) < 8);
                issue_is_load   = ($urandom_range(0, 9) < 3);
                d_mem_busy      = ($urandom_range(0, 9) == 0);
                i_mem_busy      = ($urandom_range(0, 19) < 3);
                mispredict      = ($urandom_range(0, 24) < 2);
                exception       = ($urandom_range(0, 49) == 0);
                ret             = ($urandom_range(0, 49) == 0);
                priv_pc_in      = $urandom();
                eval_check();
                advance();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
